// File: rtl/inst2code_pkg.sv
// inst2code_pkg: shared constants and types for the streaming RV32I assembler.
//   - RV32I opcode and funct3/funct7 constants for the supported subset
//   - operand-format enum (fmt_e) and FSM state enum (state_e)
//   - fmt_nops(): number of operands a format expects
package inst2code_pkg;

  localparam int MAX_MNEM = 5;            // max mnemonic letters
  localparam int MAX_HEX  = 6;            // max hex digits per immediate
  localparam int MNEM_W   = 8 * MAX_MNEM; // mnemonic buffer width
  localparam int TOK_W    = 4 * MAX_HEX;  // hex token accumulator width

  // Major opcodes
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;

  // funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;  // lw / sw
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;

  // funct7 bit 5 selects sub over add; all other funct7 bits are zero here
  localparam logic F7B5_ALT = 1'b1;

  localparam logic [31:0] NOP_CODE = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_NOP
  } fmt_e;

  typedef enum logic [2:0] {
    IDLE, MNEM, OPND, ERR_SKIP, EMIT
  } state_e;

  function automatic logic [1:0] fmt_nops(input fmt_e f);
    case (f)
      FMT_R, FMT_I, FMT_S, FMT_B: return 2'd3;
      FMT_J, FMT_U:               return 2'd2;
      default:                    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/inst2code_mnem_lut.sv
// inst2code_mnem_lut: combinational mnemonic lookup.
// The buffer holds the mnemonic right-aligned (last letter in the low byte),
// zero-padded on the left.
//   mnem     in  MNEM_W  mnemonic buffer
//   valid    out 1       mnemonic is supported
//   fmt      out fmt_e   operand format
//   opcode   out 7       major opcode
//   funct3   out 3       funct3 field
//   funct7b5 out 1       funct7 bit 5 (sub)
module inst2code_mnem_lut
  import inst2code_pkg::*;
(
  input  logic [MNEM_W-1:0] mnem,
  output logic              valid,
  output fmt_e              fmt,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic              funct7b5
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    valid    = 1'b1;
    fmt      = FMT_R;
    opcode   = OP;
    funct3   = F3_ADD;
    funct7b5 = 1'b0;
    case (mnem)
      {16'd0, "add"}:  ;
      {16'd0, "sub"}:  funct7b5 = F7B5_ALT;
      {16'd0, "and"}:  funct3 = F3_AND;
      {24'd0, "or"}:   funct3 = F3_OR;
      {16'd0, "xor"}:  funct3 = F3_XOR;
      {16'd0, "sll"}:  funct3 = F3_SLL;
      {16'd0, "srl"}:  funct3 = F3_SRL;
      {16'd0, "slt"}:  funct3 = F3_SLT;
      {8'd0,  "sltu"}: funct3 = F3_SLTU;
      {8'd0,  "addi"}: begin fmt = FMT_I; opcode = OP_IMM; end
      {8'd0,  "andi"}: begin fmt = FMT_I; opcode = OP_IMM; funct3 = F3_AND;  end
      {16'd0, "ori"}:  begin fmt = FMT_I; opcode = OP_IMM; funct3 = F3_OR;   end
      {8'd0,  "xori"}: begin fmt = FMT_I; opcode = OP_IMM; funct3 = F3_XOR;  end
      {8'd0,  "slti"}: begin fmt = FMT_I; opcode = OP_IMM; funct3 = F3_SLT;  end
      "sltiu":         begin fmt = FMT_I; opcode = OP_IMM; funct3 = F3_SLTU; end
      {8'd0,  "slli"}: begin fmt = FMT_I; opcode = OP_IMM; funct3 = F3_SLL;  end
      {8'd0,  "srli"}: begin fmt = FMT_I; opcode = OP_IMM; funct3 = F3_SRL;  end
      {8'd0,  "jalr"}: begin fmt = FMT_I; opcode = JALR; end
      {24'd0, "lw"}:   begin fmt = FMT_I; opcode = LOAD;  funct3 = F3_W; end
      {24'd0, "sw"}:   begin fmt = FMT_S; opcode = STORE; funct3 = F3_W; end
      {16'd0, "beq"}:  begin fmt = FMT_B; opcode = BRANCH; funct3 = F3_BEQ; end
      {16'd0, "bne"}:  begin fmt = FMT_B; opcode = BRANCH; funct3 = F3_BNE; end
      {16'd0, "blt"}:  begin fmt = FMT_B; opcode = BRANCH; funct3 = F3_BLT; end
      {16'd0, "jal"}:  begin fmt = FMT_J; opcode = JAL; end
      {16'd0, "lui"}:  begin fmt = FMT_U; opcode = LUI; end
      {16'd0, "nop"}:  fmt = FMT_NOP;
      default:         valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst2code.sv
// inst2code: streaming RV32I assembler. One ASCII character per handshake in,
// one 32-bit instruction word out per line terminated by '\n' or ';'.
//   clk, rst_n         clock, synchronous active-low reset
//   char_valid/ready   character handshake, char_in = ASCII byte
//   code_valid/ready   result handshake, code = instruction (0 on err)
//   err                line was malformed or unsupported
// Build option: define INST2CODE_CASEFOLD_EN to accept uppercase mnemonic
// letters, 'X' register prefixes, lowercase hex digits and 'h' suffixes.
module inst2code
  import inst2code_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_in,
  output logic        char_ready,
  output logic        code_valid,
  input  logic        code_ready,
  output logic [31:0] code,
  output logic        err
);

`ifdef INST2CODE_CASEFOLD_EN
  localparam bit CASEFOLD = 1'b1;
`else
  localparam bit CASEFOLD = 1'b0;
`endif

  state_e             state, state_n;
  logic [MNEM_W-1:0]  mnem;
  logic [2:0]         mlen;
  logic [1:0]         k;            // index of the operand being parsed
  logic               tok_x, tok_h;
  logic [2:0]         tok_n;        // hex digits seen in current token
  logic [TOK_W-1:0]   tok_val;
  logic [4:0]         r0, r1;       // completed register operands 0 and 1

  logic       lut_valid, funct7b5;
  fmt_e       fmt;
  logic [6:0] opcode;
  logic [2:0] funct3;

  inst2code_mnem_lut u_lut (
    .mnem     (mnem),
    .valid    (lut_valid),
    .fmt      (fmt),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7b5 (funct7b5)
  );

  // Character classification
  logic       fire, is_upper, is_letter, is_term, is_sp, is_comma, is_x, is_h;
  logic       is_dig, is_hex;
  logic [7:0] ch_f;
  logic [3:0] hex_nib;

  assign fire      = char_valid && char_ready;
  assign is_upper  = (char_in >= "A") && (char_in <= "Z");
  assign ch_f      = (CASEFOLD && is_upper) ? (char_in | 8'h20) : char_in;
  assign is_letter = (ch_f >= "a") && (ch_f <= "z");
  assign is_term   = (char_in == 8'h0A) || (char_in == ";");
  assign is_sp     = (char_in == " ");
  assign is_comma  = (char_in == ",");
  assign is_x      = (ch_f == "x");
  assign is_h      = CASEFOLD ? (ch_f == "h") : (char_in == "H");
  assign is_dig    = (char_in >= "0") && (char_in <= "9");
  assign is_hex    = is_dig || ((char_in >= "A") && (char_in <= "F")) ||
                     (CASEFOLD && (char_in >= "a") && (char_in <= "f"));
  // 'A'/'a' have low nibble 1, so letters map to low nibble + 9
  assign hex_nib   = is_dig ? char_in[3:0] : char_in[3:0] + 4'd9;

  // Operand context: the last operand of non-R formats is the immediate
  logic [1:0]       cnt;
  logic             op_avail, last_op, reg_op, tok_empty, shamt, imm_even;
  logic             reg_ok, imm_ok, tok_ok;
  logic [TOK_W-1:0] imm_max;

  assign cnt       = fmt_nops(fmt);
  assign op_avail  = k < cnt;
  assign last_op   = (k + 2'd1) == cnt;
  assign reg_op    = (fmt == FMT_R) || !last_op;
  assign tok_empty = !tok_x && (tok_n == 3'd0);
  assign shamt     = (fmt == FMT_I) && (opcode == OP_IMM) && (funct3[1:0] == 2'b01);
  assign imm_even  = (fmt == FMT_B) || (fmt == FMT_J);

  always_comb begin
    case (fmt)
      FMT_I:   imm_max = shamt ? TOK_W'(24'h1F) : TOK_W'(24'hFFF);
      FMT_S:   imm_max = TOK_W'(24'hFFF);
      FMT_B:   imm_max = TOK_W'(24'h1FFF);
      FMT_J:   imm_max = TOK_W'(24'h1FFFFF);
      FMT_U:   imm_max = TOK_W'(24'hFFFFF);
      default: imm_max = '0;
    endcase
  end

  assign reg_ok = tok_x && (tok_n != 3'd0) && (tok_val <= TOK_W'(24'h1F));
  assign imm_ok = !tok_x && (tok_n != 3'd0) && (tok_val <= imm_max) &&
                  !(imm_even && tok_val[0]);
  assign tok_ok = reg_op ? reg_ok : imm_ok;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and datapath actions
  logic mnem_start, mnem_push, opnd_start, store, set_x, set_h, tok_push;
  logic emit, emit_err;

  always_comb begin
    state_n    = state;
    mnem_start = 1'b0;
    mnem_push  = 1'b0;
    opnd_start = 1'b0;
    store      = 1'b0;
    set_x      = 1'b0;
    set_h      = 1'b0;
    tok_push   = 1'b0;
    emit       = 1'b0;
    emit_err   = 1'b0;
    if (state == EMIT) state_n = IDLE;
    if (fire) begin
      case (state)
        IDLE, EMIT: begin
          if (is_letter) begin
            mnem_start = 1'b1;
            state_n    = MNEM;
          end else if (!(is_sp || is_term)) begin
            state_n = ERR_SKIP;
          end
        end
        MNEM: begin
          if (is_letter) begin
            if (mlen == 3'(MAX_MNEM)) state_n = ERR_SKIP;
            else                      mnem_push = 1'b1;
          end else if (is_sp) begin
            opnd_start = lut_valid;
            state_n    = lut_valid ? OPND : ERR_SKIP;
          end else if (is_term) begin
            emit     = 1'b1;
            emit_err = !(lut_valid && (fmt == FMT_NOP));
            state_n  = EMIT;
          end else begin
            state_n = ERR_SKIP;
          end
        end
        OPND: begin
          if (is_sp) begin
            state_n = OPND;
          end else if (is_term) begin
            emit     = 1'b1;
            emit_err = !(((cnt == 2'd0) && tok_empty) || (last_op && tok_ok));
            state_n  = EMIT;
          end else if (is_comma) begin
            if (op_avail && !last_op && tok_ok) store = 1'b1;
            else                                state_n = ERR_SKIP;
          end else if (is_x) begin
            if (op_avail && reg_op && tok_empty) set_x = 1'b1;
            else                                 state_n = ERR_SKIP;
          end else if (is_hex) begin
            if (op_avail && (reg_op ? (tok_x && (tok_n < 3'd2))
                                    : (!tok_h && (tok_n < 3'(MAX_HEX)))))
              tok_push = 1'b1;
            else
              state_n = ERR_SKIP;
          end else if (is_h) begin
            if (op_avail && !reg_op && (tok_n != 3'd0) && !tok_h) set_h = 1'b1;
            else                                                  state_n = ERR_SKIP;
          end else begin
            state_n = ERR_SKIP;
          end
        end
        ERR_SKIP: begin
          if (is_term) begin
            emit     = 1'b1;
            emit_err = 1'b1;
            state_n  = EMIT;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output logic: characters are refused only while a result is stalled
  always_comb begin
    char_ready = !(code_valid && !code_ready);
  end

  // Accumulators
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mnem    <= '0;
      mlen    <= '0;
      k       <= '0;
      tok_x   <= 1'b0;
      tok_h   <= 1'b0;
      tok_n   <= '0;
      tok_val <= '0;
      r0      <= '0;
      r1      <= '0;
    end else begin
      if (mnem_start) begin
        mnem <= {{(MNEM_W-8){1'b0}}, ch_f};
        mlen <= 3'd1;
      end else if (mnem_push) begin
        mnem <= {mnem[MNEM_W-9:0], ch_f};
        mlen <= mlen + 3'd1;
      end
      if (opnd_start || store) begin
        tok_x   <= 1'b0;
        tok_h   <= 1'b0;
        tok_n   <= '0;
        tok_val <= '0;
      end
      if (opnd_start) k <= '0;
      if (store) begin
        if (k == 2'd0) r0 <= tok_val[4:0];
        else           r1 <= tok_val[4:0];
        k <= k + 2'd1;
      end
      if (set_x) tok_x <= 1'b1;
      if (set_h) tok_h <= 1'b1;
      if (tok_push) begin
        tok_val <= {tok_val[TOK_W-5:0], hex_nib};
        tok_n   <= tok_n + 3'd1;
      end
    end
  end

  // Encoding: at the terminator the final operand is still in the token
  // accumulator and the earlier register operands sit in r0/r1.
  logic [31:0] enc;
  logic [20:0] imm;
  assign imm = tok_val[20:0];

  always_comb begin
    case (fmt)
      FMT_R:   enc = {1'b0, funct7b5, 5'b0, tok_val[4:0], r1, funct3, r0, opcode};
      FMT_I:   enc = {imm[11:0], r1, funct3, r0, opcode};
      FMT_S:   enc = {imm[11:5], r1, r0, funct3, imm[4:0], opcode};
      FMT_B:   enc = {imm[12], imm[10:5], r1, r0, funct3, imm[4:1], imm[11], opcode};
      FMT_J:   enc = {imm[20], imm[10:1], imm[11], imm[19:12], r0, opcode};
      FMT_U:   enc = {imm[19:0], r0, opcode};
      default: enc = NOP_CODE;
    endcase
  end

  // Result register; emit is only possible when char_ready, so a stalled
  // result is never overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_valid <= 1'b0;
      code       <= '0;
      err        <= 1'b0;
    end else if (emit) begin
      code_valid <= 1'b1;
      code       <= emit_err ? 32'h0 : enc;
      err        <= emit_err;
    end else if (code_ready) begin
      code_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst2code.sv
// tb_inst2code: directed self-checking bench for inst2code.
module tb_inst2code;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        char_valid;
  logic [7:0]  char_in;
  logic        char_ready;
  logic        code_valid;
  logic        code_ready;
  logic [31:0] code;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  inst2code dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_in    (char_in),
    .char_ready (char_ready),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code       (code),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic send_char(input logic [7:0] c);
    char_valid = 1'b1;
    char_in    = c;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Sends a line and checks the result one cycle after the terminator.
  task automatic expect_line(input string tag, input string s,
                             input logic [31:0] exp_code, input logic exp_err);
    send_line(s);
    check({tag, ".valid"}, 32'(code_valid), 32'd1);
    check({tag, ".code"},  code, exp_code);
    check({tag, ".err"},   32'(err), 32'(exp_err));
  endtask

  initial begin
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    code_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.code_valid", 32'(code_valid), 32'd0);
    check("rst.code",       code,            32'd0);
    check("rst.err",        32'(err),        32'd0);
    check("rst.char_ready", 32'(char_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Main function
    expect_line("add",  "add x01,x02,x03\n",   32'h003100B3, 1'b0);
    @(posedge clk);
    #1;
    check("add.drop", 32'(code_valid), 32'd0);
    expect_line("addi", "addi x05,x00,7FFH\n", 32'h7FF00293, 1'b0);
    expect_line("beq",  "beq x01,x02,008;",    32'h00208463, 1'b0);
    expect_line("sub",  "sub x03,x01,x02\n",   32'h402081B3, 1'b0);
    expect_line("sw",   "sw x02,x03,104\n",    32'h10312223, 1'b0);
    expect_line("jal",  "jal x01,800\n",       32'h001000EF, 1'b0);

    // Back-to-back lines
    expect_line("lui",  "lui x0A,12345H\n",    32'h12345537, 1'b0);
    expect_line("nop",  "nop\n",               32'h00000013, 1'b0);

    // Error cases
    expect_line("mul",      "mul x01,x02,x03\n",    32'h0, 1'b1);
    expect_line("addi_ovf", "addi x01,x01,1000H\n", 32'h0, 1'b1);
    expect_line("beq_odd",  "beq x01,x02,003\n",    32'h0, 1'b1);
    expect_line("slli_big", "slli x01,x01,20\n",    32'h0, 1'b1);
    expect_line("long",     "andiii x01,x01,1\n",   32'h0, 1'b1);
    expect_line("missing",  "add x01,x02\n",        32'h0, 1'b1);
    expect_line("extra",    "nop x01\n",            32'h0, 1'b1);
`ifdef INST2CODE_CASEFOLD_EN
    expect_line("upper",    "ADD x01,x02,x03\n",    32'h003100B3, 1'b0);
    expect_line("lowhex",   "addi x01,x00,7ff\n",   32'h7FF00093, 1'b0);
`else
    expect_line("upper",    "ADD x01,x02,x03\n",    32'h0, 1'b1);
    expect_line("lowhex",   "addi x01,x00,7ff\n",   32'h0, 1'b1);
`endif

    // Backpressure: result held for 3 cycles, accepted on the 4th
    @(posedge clk);
    #1;
    code_ready = 1'b0;
    expect_line("bp", "add x01,x02,x03\n", 32'h003100B3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check("bp.char_ready", 32'(char_ready), 32'd0);
      check("bp.valid",      32'(code_valid), 32'd1);
      check("bp.code",       code,            32'h003100B3);
      if (c < 2) begin
        @(posedge clk);
        #1;
      end
    end
    code_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.accepted",  32'(code_valid), 32'd0);
    check("bp.ready_back", 32'(char_ready), 32'd1);

    // Reset in the middle of a line
    send_line("add x01,");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst.valid",      32'(code_valid), 32'd0);
    check("mrst.char_ready", 32'(char_ready), 32'd1);
    expect_line("mrst_nop", "nop\n", 32'h00000013, 1'b0);
    @(posedge clk);
    #1;
    check("mrst.single", 32'(code_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
